// File: rtl/cntr8_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : cntr8_pkg                                                       |
// | Brief    : Shared state encodings and count constants for cntr8_updown_ctrl|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cntr8_pkg;

    localparam int CNTR8_WIDTH = 3;
    localparam int MAX_CNT     = (1 << CNTR8_WIDTH) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    function automatic logic state_is_legal(input logic [1:0] s);
        return (s != 2'b11);
    endfunction

endpackage : cntr8_pkg
`default_nettype wire

// File: rtl/cntr8_ns_logic.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : cntr8_ns_logic                                                  |
// | Brief    : Combinational next-count / next-state / next-tc logic.          |
// |            Macro CNTR8_SATURATE_EN selects saturating instead of wrapping. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cntr8_ns_logic
    import cntr8_pkg::*;
#(
    parameter int WIDTH = CNTR8_WIDTH
) (
    input  logic             load,
    input  logic             en,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] d_load,
    input  logic [WIDTH-1:0] cnt_q,
    input  logic [1:0]       state_q,
    output logic [WIDTH-1:0] cnt_d,
    output logic             tc_d,
    output logic [1:0]       state_d
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic at_max;
    logic at_min;

    assign at_max = (cnt_q == MAX_VAL);
    assign at_min = (cnt_q == MIN_VAL);

    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        state_d = S_IDLE;

        if (load) begin
            cnt_d = d_load;
        end else if (en) begin
            if (up_dn) begin
                state_d = S_UP;
`ifdef CNTR8_SATURATE_EN
                if (at_max) tc_d  = 1'b1;
                else        cnt_d = cnt_q + WIDTH'(1);
`else
                cnt_d = cnt_q + WIDTH'(1);
                tc_d  = at_max;
`endif
            end else begin
                state_d = S_DOWN;
`ifdef CNTR8_SATURATE_EN
                if (at_min) tc_d  = 1'b1;
                else        cnt_d = cnt_q - WIDTH'(1);
`else
                cnt_d = cnt_q - WIDTH'(1);
                tc_d  = at_min;
`endif
            end
        end

        // An unreachable encoding still recovers to idle on the next edge.
        if (!state_is_legal(state_q)) begin
            state_d = S_IDLE;
        end
    end

endmodule : cntr8_ns_logic
`default_nettype wire

// File: rtl/cntr8_updown_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : cntr8_updown_ctrl                                               |
// | Brief    : Up/down counter with load, terminal-count pulse and state out.  |
// |            Define CNTR8_SATURATE_EN for saturating mode (default: wrap).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cntr8_updown_ctrl
    import cntr8_pkg::*;
#(
    parameter int WIDTH = CNTR8_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d_load,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic [1:0]       state
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic [1:0]       state_q;
    logic [1:0]       state_d;

    cntr8_ns_logic #(
        .WIDTH   (WIDTH)
    ) u_ns_logic (
        .load    (load),
        .en      (en),
        .up_dn   (up_dn),
        .d_load  (d_load),
        .cnt_q   (cnt_q),
        .state_q (state_q),
        .cnt_d   (cnt_d),
        .tc_d    (tc_d),
        .state_d (state_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign cnt   = cnt_q;
    assign tc    = tc_q;
    assign state = state_q;

endmodule : cntr8_updown_ctrl
`default_nettype wire

// File: tb/tb_cntr8_updown_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_cntr8_updown_ctrl                                            |
// | Brief    : Self-checking bench: reference model plus directed/random runs. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cntr8_updown_ctrl;

    localparam int W    = 3;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] d_load;
    logic [W-1:0] cnt;
    logic         tc;
    logic [1:0]   state;

    int n_tests;
    int n_fail;

    int m_cnt;
    int m_tc;
    int m_st;

    cntr8_updown_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .d_load  (d_load),
        .cnt     (cnt),
        .tc      (tc),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counter value as a plain integer with modular arithmetic.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_tc = 0; m_st = 0;
        end else if (load) begin
            m_cnt = int'(d_load); m_tc = 0; m_st = 0;
        end else if (!en) begin
            m_tc = 0; m_st = 0;
        end else if (up_dn) begin
            m_st = 1;
`ifdef CNTR8_SATURATE_EN
            if (m_cnt == MAXV) m_tc = 1;
            else begin m_cnt = m_cnt + 1; m_tc = 0; end
`else
            m_tc  = (m_cnt == MAXV) ? 1 : 0;
            m_cnt = (m_cnt + 1) % MODV;
`endif
        end else begin
            m_st = 2;
`ifdef CNTR8_SATURATE_EN
            if (m_cnt == 0) m_tc = 1;
            else begin m_cnt = m_cnt - 1; m_tc = 0; end
`else
            m_tc  = (m_cnt == 0) ? 1 : 0;
            m_cnt = (m_cnt + MODV - 1) % MODV;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("model_cnt",   int'(cnt),   m_cnt);
        check("model_tc",    int'(tc),    m_tc);
        check("model_state", int'(state), m_st);
    end

    task automatic step(input logic l, input logic [W-1:0] d, input logic e, input logic u);
        @(negedge clk);
        load = l; d_load = d; en = e; up_dn = u;
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name, input int c, input int t, input int s);
        check({name, "_cnt"},   int'(cnt),   c);
        check({name, "_tc"},    int'(tc),    t);
        check({name, "_state"}, int'(state), s);
    endtask

    task automatic async_reset_pulse(input string name);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 pin(name, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int up_c [9];
    int up_t [9];

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; d_load = '0;
        @(posedge clk); #2;
        pin("reset_hold", 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;

        // Mid-cycle async reset with cnt=5.
        step(1'b1, 3'd5, 1'b0, 1'b0);
        pin("load5", 5, 0, 0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        async_reset_pulse("async_rst_cnt5");

`ifdef CNTR8_SATURATE_EN
        up_c = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
        up_t = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
`else
        up_c = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        up_t = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 3'd0, 1'b1, 1'b1);
            pin($sformatf("up_%0d", i), up_c[i], up_t[i], 1);
        end

`ifdef CNTR8_SATURATE_EN
        step(1'b1, 3'd6, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1); pin("sat_up0", 7, 0, 1);
        step(1'b0, 3'd0, 1'b1, 1'b1); pin("sat_up1", 7, 1, 1);
        step(1'b0, 3'd0, 1'b1, 1'b1); pin("sat_up2", 7, 1, 1);
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0); pin("sat_dn0", 0, 1, 2);
        step(1'b1, 3'd1, 1'b0, 1'b0);
`else
        // Count is 1 here; down through the 0->7 wrap.
        step(1'b0, 3'd0, 1'b1, 1'b0); pin("dn_0", 0, 0, 2);
        step(1'b0, 3'd0, 1'b1, 1'b0); pin("dn_1", 7, 1, 2);
        step(1'b0, 3'd0, 1'b1, 1'b0); pin("dn_2", 6, 0, 2);
`endif

        step(1'b1, 3'd5, 1'b1, 1'b1); pin("load_over_en", 5, 0, 0);
        step(1'b0, 3'd0, 1'b0, 1'b1); pin("hold_0", 5, 0, 0);
        step(1'b0, 3'd0, 1'b0, 1'b0); pin("hold_1", 5, 0, 0);

        step(1'b1, 3'd7, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b1); pin("load_beats_wrap", 2, 0, 0);

        // Direction change with no idle gap.
        step(1'b0, 3'd0, 1'b1, 1'b1); pin("dir_up", 3, 0, 1);
        step(1'b0, 3'd0, 1'b1, 1'b0); pin("dir_dn", 2, 0, 2);

`ifndef CNTR8_SATURATE_EN
        // Pending tc discarded by reset.
        step(1'b1, 3'd7, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1); pin("tc_pending", 0, 1, 1);
        @(negedge clk); en = 1'b0;
        async_reset_pulse("rst_drops_tc");
`endif

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 7) == 0);
            d_load = W'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            up_dn  = ($urandom_range(0, 4) < 3) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 63) == 0) begin
                @(posedge clk);
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        @(posedge clk); #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cntr8_updown_ctrl
`default_nettype wire
